// File: rtl/qpu_exu_qdec_pipe_pkg.sv
// qpu_exu_qdec_pipe_pkg: opcode constants, field positions and decode helpers
// shared by the quantum decode stage.
package qpu_exu_qdec_pipe_pkg;

    typedef enum logic [4:0] {
        OP_QWAIT = 5'b10010,
        OP_FMR   = 5'b11010,
        OP_HALT  = 5'b11110
    } cop_e;

    localparam logic [8:0] MEAS_OP1 = 9'h0FF;
    localparam int PI_LSB  = 29;
    localparam int WD_A_LSB = 5;
    localparam int WD_B_LSB = 24;
    localparam int WD_C_LSB = 10;
    localparam int WD_D_LSB = 15;

    typedef struct packed {
        logic quantum;
        logic qwait;
        logic fmr;
        logic halt;
        logic measure;
        logic new_tp;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.quantum = ins[0];
        d.qwait   = ins[4:0] == OP_QWAIT;
        d.fmr     = ins[4:0] == OP_FMR;
        d.halt    = ins[4:0] == OP_HALT;
        d.measure = ins[0] & (ins[9:1] == MEAS_OP1);
        d.new_tp  = d.qwait | (ins[0] & |ins[PI_LSB +: 3]);
        return d;
    endfunction

    // Scrambled 27-bit QWAIT wait count, most significant slice first.
    function automatic logic [26:0] w_delta(input logic [31:0] ins);
        return {ins[PI_LSB +: 3], ins[WD_A_LSB +: 5], ins[WD_B_LSB +: 5],
                ins[WD_C_LSB +: 5], ins[WD_D_LSB +: 9]};
    endfunction

endpackage

// File: rtl/qpu_exu_qdec_pipe_if.sv
// qpu_exu_qdec_pipe_if: upstream/downstream handshake, measurement return and
// status signals of the quantum decode stage.
interface qpu_exu_qdec_pipe_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int TIME_W  = 32,
    parameter int MEAS_CW = 4
);
    logic               i_valid;
    logic               i_ready;
    logic [INSTR_W-1:0] i_instr;
    logic [PC_W-1:0]    i_pc;
    logic               i_meas_done;
    logic               i_flush;
    logic               o_valid;
    logic               o_ready;
    logic [INSTR_W-1:0] o_instr;
    logic [PC_W-1:0]    o_pc;
    logic [TIME_W-1:0]  o_timepoint;
    logic               o_new_tp;
    logic               o_measure;
    logic               o_fmr;
    logic               o_halt;
    logic               o_halted;
    logic [MEAS_CW-1:0] o_meas_pend;
    logic               o_meas_err;

    modport master (
        output i_valid, i_instr, i_pc, i_meas_done, i_flush, o_ready,
        input  i_ready, o_valid, o_instr, o_pc, o_timepoint, o_new_tp,
               o_measure, o_fmr, o_halt, o_halted, o_meas_pend, o_meas_err
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_meas_done, i_flush, o_ready,
        output i_ready, o_valid, o_instr, o_pc, o_timepoint, o_new_tp,
               o_measure, o_fmr, o_halt, o_halted, o_meas_pend, o_meas_err
    );
endinterface

// File: rtl/qpu_exu_qdec_pipe_meas_scoreboard.sv
// qpu_meas_scoreboard: outstanding-measurement up/down counter with full/empty
// flags and a registered pulse for a result that arrives with nothing pending.
module qpu_meas_scoreboard #(
    parameter int MEAS_MAX = 8,
    parameter int MEAS_CW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    output logic [MEAS_CW-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               err
);
    assign full  = count == MEAS_CW'(MEAS_MAX);
    assign empty = count == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err   <= dec & ~inc & empty;
            count <= (inc & ~dec & ~full)  ? count + 1'b1 :
                     (dec & ~inc & ~empty) ? count - 1'b1 : count;
        end
    end
endmodule

// File: rtl/qpu_exu_qdec_pipe.sv
// qpu_exu_qdec_pipe: registered decode stage with timepoint accumulation,
// measurement scoreboard stalls and a sticky halt.
module qpu_exu_qdec_pipe
    import qpu_exu_qdec_pipe_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int PC_W     = 32,
    parameter int TIME_W   = 32,
    parameter int MEAS_MAX = 8,
    parameter int MEAS_CW  = 4
) (
    input logic clk,
    input logic rst_n,
    qpu_exu_qdec_pipe_if.slave bus
);
    dec_t              d;
    logic [TIME_W-1:0] delta;
    logic              full;
    logic              empty;
    logic              stall;
    logic              accept;

    assign d     = decode(bus.i_instr[31:0]);
    assign delta = d.qwait   ? TIME_W'(w_delta(bus.i_instr[31:0])) :
                   d.quantum ? TIME_W'(bus.i_instr[PI_LSB +: 3]) : '0;
    // A returning result frees a slot in the same cycle, so a full scoreboard
    // still takes a MEASURE when i_meas_done is high.
    assign stall = (d.fmr & ~empty) | (d.measure & full & ~bus.i_meas_done);
    assign bus.i_ready = (~bus.o_valid | bus.o_ready) & ~stall & ~bus.o_halted & ~bus.i_flush;
    assign accept = bus.i_valid & bus.i_ready;

    qpu_meas_scoreboard #(
        .MEAS_MAX(MEAS_MAX),
        .MEAS_CW (MEAS_CW)
    ) u_sb (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (accept & d.measure),
        .dec  (bus.i_meas_done),
        .count(bus.o_meas_pend),
        .full (full),
        .empty(empty),
        .err  (bus.o_meas_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_valid     <= 1'b0;
            bus.o_instr     <= '0;
            bus.o_pc        <= '0;
            bus.o_timepoint <= '0;
            bus.o_new_tp    <= 1'b0;
            bus.o_measure   <= 1'b0;
            bus.o_fmr       <= 1'b0;
            bus.o_halt      <= 1'b0;
            bus.o_halted    <= 1'b0;
        end else if (bus.i_flush) begin
            bus.o_valid  <= 1'b0;
            bus.o_halted <= 1'b0;
        end else if (accept) begin
            bus.o_valid     <= 1'b1;
            bus.o_instr     <= bus.i_instr;
            bus.o_pc        <= bus.i_pc;
            bus.o_timepoint <= bus.o_timepoint + delta;
            bus.o_new_tp    <= d.new_tp;
            bus.o_measure   <= d.measure;
            bus.o_fmr       <= d.fmr;
            bus.o_halt      <= d.halt;
            bus.o_halted    <= d.halt;
        end else if (bus.o_ready) begin
            bus.o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_qpu_exu_qdec_pipe.sv
// tb_qpu_exu_qdec_pipe: directed vector table, reset-mid-stall sequence and
// randomized traffic against an integer reference model.
module tb_qpu_exu_qdec_pipe;
    localparam int TW = 8;
    localparam int MM = 2;
    localparam int MC = 2;

    localparam bit [31:0] Q3   = 32'h6000_0001;
    localparam bit [31:0] Q0   = 32'h0000_0001;
    localparam bit [31:0] W100 = 32'h0032_0012;
    localparam bit [31:0] W147 = 32'h0049_8012;
    localparam bit [31:0] W10  = 32'h0005_0012;
    localparam bit [31:0] MS   = 32'h0000_01FF;
    localparam bit [31:0] FM   = 32'h0000_001A;
    localparam bit [31:0] HT   = 32'h0000_001E;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qpu_exu_qdec_pipe_if #(.INSTR_W(32), .PC_W(32), .TIME_W(TW), .MEAS_CW(MC)) bus ();

    qpu_exu_qdec_pipe #(
        .INSTR_W(32), .PC_W(32), .TIME_W(TW), .MEAS_MAX(MM), .MEAS_CW(MC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    bit          m_valid, m_halted, m_err;
    bit [31:0]   m_instr, m_pc;
    int unsigned m_tp;
    int          m_pend;
    bit [3:0]    m_flags;
    bit          m_rdy;
    logic        dut_rdy;

    typedef struct {
        bit        v;
        bit [31:0] ins;
        bit        dn, fl, ordy;
        bit        rdy, ov;
        bit [31:0] oins;
        int        tp;
        bit [3:0]  flags;
        int        pend;
        bit        err, hlt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned wd(input bit [31:0] x);
        return ((x >> 29) << 24) | (((x >> 5) & 31) << 19) | (((x >> 24) & 31) << 14)
             | (((x >> 10) & 31) << 9) | ((x >> 15) & 511);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_halted = 0; m_err = 0; m_instr = 0; m_pc = 0;
        m_tp = 0; m_pend = 0; m_flags = 0;
    endtask

    task automatic model_step(input bit v, input bit [31:0] ins, input bit [31:0] pc,
                              input bit dn, input bit fl, input bit ordy);
        int unsigned op, pi, dl;
        bit q, qw, fm, hl, ms, acc;
        op = ins & 31;
        q  = (ins & 1) != 0;
        qw = op == 18;
        fm = op == 26;
        hl = op == 30;
        ms = q && ((ins >> 1) & 511) == 255;
        pi = ins >> 29;
        dl = qw ? wd(ins) : q ? pi : 0;
        m_rdy = (!m_valid || ordy) && !(fm && m_pend != 0) && !(ms && m_pend == MM && !dn)
                && !m_halted && !fl;
        acc = v && m_rdy;
        m_err = dn && m_pend == 0 && !(acc && ms);
        m_pend = m_pend + ((acc && ms) ? 1 : 0) - (dn ? 1 : 0);
        if (m_pend < 0) m_pend = 0;
        if (fl) begin
            m_valid = 0;
            m_halted = 0;
        end else if (acc) begin
            m_valid = 1;
            m_instr = ins;
            m_pc = pc;
            m_tp = (m_tp + dl) % (1 << TW);
            m_flags = {qw || (q && pi != 0), ms, fm, hl};
            if (hl) m_halted = 1;
        end else if (ordy) begin
            m_valid = 0;
        end
    endtask

    task automatic drive(input bit v, input bit [31:0] ins, input bit [31:0] pc,
                         input bit dn, input bit fl, input bit ordy);
        bus.i_valid = v; bus.i_instr = ins; bus.i_pc = pc;
        bus.i_meas_done = dn; bus.i_flush = fl; bus.o_ready = ordy;
        #1;
        dut_rdy = bus.i_ready;
        model_step(v, ins, pc, dn, fl, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " ready"},   64'(dut_rdy), 64'(m_rdy));
        chk({tag, " valid"},   64'(bus.o_valid), 64'(m_valid));
        chk({tag, " instr"},   64'(bus.o_instr), 64'(m_instr));
        chk({tag, " pc"},      64'(bus.o_pc), 64'(m_pc));
        chk({tag, " tp"},      64'(bus.o_timepoint), 64'(m_tp));
        chk({tag, " flags"},   64'({bus.o_new_tp, bus.o_measure, bus.o_fmr, bus.o_halt}), 64'(m_flags));
        chk({tag, " pend"},    64'(bus.o_meas_pend), 64'(m_pend));
        chk({tag, " err"},     64'(bus.o_meas_err), 64'(m_err));
        chk({tag, " halted"},  64'(bus.o_halted), 64'(m_halted));
    endtask

    function automatic vec_t mk(bit v, bit [31:0] ins, bit dn, bit fl, bit ordy, bit rdy, bit ov,
                                bit [31:0] oins, int tp, bit [3:0] flags, int pend, bit err, bit hlt);
        vec_t r;
        r.v = v; r.ins = ins; r.dn = dn; r.fl = fl; r.ordy = ordy; r.rdy = rdy; r.ov = ov;
        r.oins = oins; r.tp = tp; r.flags = flags; r.pend = pend; r.err = err; r.hlt = hlt;
        return r;
    endfunction

    initial begin
        bit [31:0] r, ins;
        bit v, dn, fl, ordy;
        int k;
        // flags column is {new_tp, measure, fmr, halt}
        tbl.push_back(mk(1, Q3,   0, 0, 1, 1, 1, Q3,   3,   4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, Q0,   0, 0, 1, 1, 1, Q0,   3,   4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, W100, 0, 0, 1, 1, 1, W100, 103, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, W147, 0, 0, 1, 1, 1, W147, 250, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, W10,  0, 0, 1, 1, 1, W10,  4,   4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, MS,   0, 0, 1, 1, 1, MS,   4,   4'b0100, 1, 0, 0));
        tbl.push_back(mk(1, MS,   0, 0, 1, 1, 1, MS,   4,   4'b0100, 2, 0, 0));
        tbl.push_back(mk(1, MS,   0, 0, 1, 0, 0, MS,   4,   4'b0100, 2, 0, 0));
        tbl.push_back(mk(1, MS,   1, 0, 1, 1, 1, MS,   4,   4'b0100, 2, 0, 0));
        tbl.push_back(mk(0, 0,    1, 0, 1, 1, 0, MS,   4,   4'b0100, 1, 0, 0));
        tbl.push_back(mk(1, FM,   0, 0, 1, 0, 0, MS,   4,   4'b0100, 1, 0, 0));
        tbl.push_back(mk(1, FM,   1, 0, 1, 0, 0, MS,   4,   4'b0100, 0, 0, 0));
        tbl.push_back(mk(1, FM,   0, 0, 1, 1, 1, FM,   4,   4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 0,    1, 0, 1, 1, 0, FM,   4,   4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 0,    0, 0, 1, 1, 0, FM,   4,   4'b0010, 0, 0, 0));
        tbl.push_back(mk(1, Q3,   0, 0, 1, 1, 1, Q3,   7,   4'b1000, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, W100, 0, 0, 0, 0, 1, Q3, 7, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, W100, 0, 0, 1, 1, 1, W100, 107, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, HT,   0, 0, 1, 1, 1, HT,   107, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(1, Q3,   0, 0, 0, 0, 1, HT,   107, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(1, Q3,   0, 0, 1, 0, 0, HT,   107, 4'b0001, 0, 0, 1));
        tbl.push_back(mk(1, Q3,   0, 1, 1, 0, 0, HT,   107, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, Q3,   0, 0, 1, 1, 1, Q3,   110, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, Q3,   0, 1, 0, 0, 0, Q3,   110, 4'b1000, 0, 0, 0));

        bus.i_valid = 0; bus.i_instr = 0; bus.i_pc = 0;
        bus.i_meas_done = 0; bus.i_flush = 0; bus.o_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid",  64'(bus.o_valid), 0);
        chk("rst tp",     64'(bus.o_timepoint), 0);
        chk("rst pend",   64'(bus.o_meas_pend), 0);
        chk("rst halted", 64'(bus.o_halted), 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("post-rst instr", 64'(bus.o_instr), 0);
        chk("post-rst flags", 64'({bus.o_new_tp, bus.o_measure, bus.o_fmr, bus.o_halt, bus.o_meas_err}), 0);

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].v, tbl[i].ins, 32'h100 + 32'(i) * 4, tbl[i].dn, tbl[i].fl, tbl[i].ordy);
            chk({t, " ready"},  64'(dut_rdy), 64'(tbl[i].rdy));
            chk({t, " valid"},  64'(bus.o_valid), 64'(tbl[i].ov));
            chk({t, " instr"},  64'(bus.o_instr), 64'(tbl[i].oins));
            chk({t, " tp"},     64'(bus.o_timepoint), 64'(tbl[i].tp));
            chk({t, " flags"},  64'({bus.o_new_tp, bus.o_measure, bus.o_fmr, bus.o_halt}), 64'(tbl[i].flags));
            chk({t, " pend"},   64'(bus.o_meas_pend), 64'(tbl[i].pend));
            chk({t, " err"},    64'(bus.o_meas_err), 64'(tbl[i].err));
            chk({t, " halted"}, 64'(bus.o_halted), 64'(tbl[i].hlt));
        end

        // Reset asserted while a second MEASURE is stalled behind a held one.
        drive(1, MS, 32'h500, 0, 0, 0);
        chk("stall held valid", 64'(bus.o_valid), 1);
        chk("stall held pend",  64'(bus.o_meas_pend), 1);
        drive(1, MS, 32'h504, 0, 0, 0);
        chk("stall ready", 64'(dut_rdy), 0);
        #2;
        rst_n = 0;
        #1;
        chk("async rst valid", 64'(bus.o_valid), 0);
        chk("async rst tp",    64'(bus.o_timepoint), 0);
        chk("async rst pend",  64'(bus.o_meas_pend), 0);
        chk("async rst instr", 64'(bus.o_instr), 0);
        bus.i_valid = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int n = 0; n < 500; n++) begin
            r = $urandom;
            k = $urandom_range(0, 9);
            ins = (k < 2) ? r :
                  (k < 4) ? (r | 32'h1) :
                  (k == 4) ? ((r & ~32'h3FF) | 32'h1FF) :
                  (k < 7) ? ((r & ~32'h1F) | 32'h12) :
                  (k == 7) ? ((r & ~32'h1F) | 32'h1A) :
                  (k == 8 && $urandom_range(0, 3) == 0) ? ((r & ~32'h1F) | 32'h1E) : (r & ~32'h1);
            v    = $urandom_range(0, 3) != 0;
            dn   = $urandom_range(0, 3) == 0;
            fl   = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
            ordy = $urandom_range(0, 9) < 7;
            drive(v, ins, $urandom, dn, fl, ordy);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
